// File: rtl/rangebin_segmenter.sv
// Captures one pulse of packed samples into a buffer, then replays it as
// fixed-length range-bin frames (bin samples followed by zero padding).
module rangebin_segmenter #(
   parameter int DATA_W          = 16,
   parameter int LANES           = 2,
   parameter int TOTAL_POINT     = 100,
   parameter int RANGEBIN_LENGTH = 25,
   parameter int NFFT            = 64,
   parameter int OVERLAP         = 0,
   parameter int BUF_DEPTH       = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_W*LANES-1:0] data_in,
   input  logic                    in_valid,
   output logic [DATA_W-1:0]       data_out,
   output logic                    data_valid,
   input  logic                    data_ready,
   output logic                    sof,
   output logic                    eof,
   output logic [7:0]              bin_idx,
   output logic                    busy,
   output logic                    done,
   output logic                    start_err
);

   localparam int NSAMP  = TOTAL_POINT * LANES;
   localparam int STEP   = RANGEBIN_LENGTH - OVERLAP;
   localparam int NBINS  = (NSAMP - OVERLAP) / STEP;
   localparam int ADDR_W = $clog2(BUF_DEPTH);
   localparam int WORD_W = $clog2(TOTAL_POINT) + 1;
   localparam int BEAT_W = $clog2(NFFT) + 1;
   localparam int BIN_W  = $clog2(NBINS) + 1;

   localparam logic [WORD_W-1:0] LAST_WORD      = WORD_W'(TOTAL_POINT - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT      = BEAT_W'(NFFT - 1);
   localparam logic [BEAT_W-1:0] LAST_DATA_BEAT = BEAT_W'(RANGEBIN_LENGTH - 1);
   localparam logic [BIN_W-1:0]  LAST_BIN       = BIN_W'(NBINS - 1);
   localparam logic [ADDR_W-1:0] STEP_A         = ADDR_W'(STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_EMIT_DATA,
      S_EMIT_ZERO,
      S_DONE
   } state_t;

   state_t              r_state, w_next;
   logic [WORD_W-1:0]   r_word;
   logic [BEAT_W-1:0]   r_beat;
   logic [BIN_W-1:0]    r_bin;
   logic [ADDR_W-1:0]   r_base;
   logic                r_drain;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic                r_sof;
   logic                r_eof;
   logic [7:0]          r_bin_out;
   logic                r_start_err;
   logic [DATA_W-1:0]   r_buf [BUF_DEPTH];

   logic                w_emit;
   logic                w_load;
   logic                w_last_beat;
   logic                w_last_bin;
   logic [ADDR_W-1:0]   w_wr_base;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [DATA_W-1:0]   w_rd_data;

   assign w_emit      = (r_state == S_EMIT_DATA) || (r_state == S_EMIT_ZERO);
   // A new beat enters the output register whenever it is empty or draining.
   assign w_load      = w_emit && !r_drain && (!r_valid || data_ready);
   assign w_last_beat = (r_beat == LAST_BEAT);
   assign w_last_bin  = (r_bin == LAST_BIN);
   assign w_wr_base   = ADDR_W'(r_word * LANES);
   assign w_rd_addr   = r_base + ADDR_W'(r_beat);
   assign w_rd_data   = r_buf[w_rd_addr];

   // NOTE: the sample buffer carries no reset; its contents are only read after a full capture.
   always_ff @(posedge clk) begin
      if (r_state == S_CAPTURE && in_valid) begin
         for (int l = 0; l < LANES; l++) begin
            r_buf[w_wr_base + ADDR_W'(l)] <= data_in[l*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: w_next gets a default first so no path through the case infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_CAPTURE;
         S_CAPTURE: if (in_valid && r_word == LAST_WORD) w_next = S_EMIT_DATA;
         S_EMIT_DATA, S_EMIT_ZERO: begin
            if (r_drain) begin
               if (!r_valid || data_ready) w_next = S_DONE;
            end else if (w_load) begin
               if (w_last_beat) begin
                  if (!w_last_bin) w_next = S_EMIT_DATA;
               end else if (r_beat == LAST_DATA_BEAT) begin
                  w_next = S_EMIT_ZERO;
               end
            end
         end
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // NOTE: all state below updates with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_word      <= '0;
         r_beat      <= '0;
         r_bin       <= '0;
         r_base      <= '0;
         r_drain     <= 1'b0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_sof       <= 1'b0;
         r_eof       <= 1'b0;
         r_bin_out   <= '0;
         r_start_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_start_err <= start && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_word  <= '0;
                  r_beat  <= '0;
                  r_bin   <= '0;
                  r_base  <= '0;
                  r_drain <= 1'b0;
                  r_valid <= 1'b0;
               end
            end
            S_CAPTURE: if (in_valid) r_word <= r_word + 1'b1;
            S_EMIT_DATA, S_EMIT_ZERO: begin
               if (r_drain) begin
                  if (!r_valid || data_ready) r_valid <= 1'b0;
               end else if (w_load) begin
                  r_valid   <= 1'b1;
                  r_data    <= (r_state == S_EMIT_DATA) ? w_rd_data : '0;
                  r_sof     <= (r_beat == '0);
                  r_eof     <= w_last_beat;
                  r_bin_out <= 8'(r_bin);
                  if (w_last_beat) begin
                     if (w_last_bin) begin
                        r_drain <= 1'b1;
                     end else begin
                        r_beat <= '0;
                        r_bin  <= r_bin + 1'b1;
                        r_base <= r_base + STEP_A;
                     end
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign sof        = r_sof;
   assign eof        = r_eof;
   assign bin_idx    = r_bin_out;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign start_err  = r_start_err;

endmodule

// File: tb/tb_rangebin_segmenter.sv
// Randomized bench for rangebin_segmenter: frames are compared against a
// reference built directly from the captured sample list.
module tb_rangebin_segmenter;

   localparam int DW    = 16;
   localparam int LANES = 2;
   localparam int TP    = 100;
   localparam int RBL   = 25;
   localparam int NFFT  = 64;
   localparam int NS    = TP * LANES;

   typedef struct packed {
      logic [7:0]    bin;
      logic          sof;
      logic          eof;
      logic [DW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, start0, start1, in_valid, data_ready;
   logic [DW*LANES-1:0] data_in;

   logic [DW-1:0] dout0, dout1;
   logic          val0, val1, sof0, sof1, eof0, eof1;
   logic [7:0]    bin0, bin1;
   logic          busy0, busy1, done0, done1, err0, err1;

   int    total = 0;
   int    bad   = 0;
   beat_t q0[$], q1[$], exp_q[$];
   int    done_cnt[2];
   int    err_cnt[2];
   int    stall_bad;
   int    smp[NS];

   rangebin_segmenter dut0 (
      .clk(clk), .rst(rst), .start(start0), .data_in(data_in), .in_valid(in_valid),
      .data_out(dout0), .data_valid(val0), .data_ready(data_ready), .sof(sof0), .eof(eof0),
      .bin_idx(bin0), .busy(busy0), .done(done0), .start_err(err0)
   );

   rangebin_segmenter #(.OVERLAP(5)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .data_in(data_in), .in_valid(in_valid),
      .data_out(dout1), .data_valid(val1), .data_ready(data_ready), .sof(sof1), .eof(eof1),
      .bin_idx(bin1), .busy(busy1), .done(done1), .start_err(err1)
   );

   beat_t cur0, cur1, p_beat;
   logic  p_stall = 1'b0;
   assign cur0 = {bin0, sof0, eof0, dout0};
   assign cur1 = {bin1, sof1, eof1, dout1};

   // Inputs change just after posedge, so the negedge view matches the next transfer edge.
   always @(negedge clk) begin
      if (val0 && data_ready) q0.push_back(cur0);
      if (val1 && data_ready) q1.push_back(cur1);
      if (done0) done_cnt[0] <= done_cnt[0] + 1;
      if (done1) done_cnt[1] <= done_cnt[1] + 1;
      if (err0)  err_cnt[0]  <= err_cnt[0] + 1;
      if (err1)  err_cnt[1]  <= err_cnt[1] + 1;
      if (p_stall && !(val0 && cur0 == p_beat)) stall_bad <= stall_bad + 1;
      p_stall <= val0 && !data_ready;
      p_beat  <= cur0;
   end

   task automatic clear_mon();
      q0.delete();
      q1.delete();
      done_cnt  = '{0, 0};
      err_cnt   = '{0, 0};
      stall_bad = 0;
   endtask

   // Expected frames straight from the bin rules: sample list sliced, zero padded.
   task automatic build_model(input int ovl);
      int    step, nb;
      beat_t e;
      step = RBL - ovl;
      nb   = (NS - ovl) / step;
      exp_q.delete();
      for (int k = 0; k < nb; k++) begin
         for (int b = 0; b < NFFT; b++) begin
            e.bin  = 8'(k);
            e.sof  = (b == 0);
            e.eof  = (b == NFFT - 1);
            e.data = (b < RBL) ? DW'(smp[k*step + b]) : '0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic capture(input int sel, input bit toggle, input bit rnd);
      int n = 0;
      int c = 0;
      int s;
      bit v;
      @(posedge clk); #1;
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      while (n < TP) begin
         v        = !toggle || (c % 2 == 0);
         in_valid = v;
         for (int l = 0; l < LANES; l++) begin
            s = v ? (rnd ? int'($urandom_range(0, 65535)) : n*LANES + l)
                  : int'($urandom_range(0, 65535));
            data_in[l*DW +: DW] = DW'(s);
            if (v) smp[n*LANES + l] = s;
         end
         if (v) n++;
         c++;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         data_in  = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int sel, input bit rnd_ready, input int err_bin);
      int c = 0;
      bit injected = 1'b0;
      while (done_cnt[sel] == 0 && c < 6000) begin
         data_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (err_bin >= 0 && !injected && val0 && bin0 == 8'(err_bin)) begin
            start0   = 1'b1;
            injected = 1'b1;
         end else begin
            start0 = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      start0     = 1'b0;
      data_ready = 1'b1;
      total++;
      if (done_cnt[sel] == 0) begin
         bad++;
         $display("FAIL done_timeout dut%0d: no done after %0d cycles", sel, c);
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic compare_q(input int sel, input string name);
      beat_t got[$];
      int    n, mis;
      if (sel == 1) got = q1; else got = q0;
      total++;
      if (got.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL %s_count: got %0d beats, expected %0d", name, got.size(), exp_q.size());
      end
      n   = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      mis = -1;
      for (int i = 0; i < n; i++) if (mis < 0 && got[i] !== exp_q[i]) mis = i;
      total++;
      if (mis >= 0) begin
         bad++;
         $display("FAIL %s_beats at %0d: got bin=%0d sof=%0b eof=%0b data=%0d, expected bin=%0d sof=%0b eof=%0b data=%0d",
                  name, mis, got[mis].bin, got[mis].sof, got[mis].eof, got[mis].data,
                  exp_q[mis].bin, exp_q[mis].sof, exp_q[mis].eof, exp_q[mis].data);
      end
      total++;
      if (done_cnt[sel] !== 1) begin
         bad++;
         $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt[sel]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({val0, sof0, eof0, done0, err0, busy0} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl0: got %b, expected 000000", {val0, sof0, eof0, done0, err0, busy0});
      end
      total++;
      if (dout0 !== '0 || bin0 !== '0) begin
         bad++;
         $display("FAIL reset_data0: got data=%0d bin=%0d, expected 0/0", dout0, bin0);
      end
      total++;
      if ({val1, sof1, eof1, done1, err1, busy1} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl1: got %b, expected 000000", {val1, sof1, eof1, done1, err1, busy1});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      clear_mon();
      capture(0, 1'b0, 1'b0);
      wait_done(0, 1'b0, -1);
      build_model(0);
      compare_q(0, "ramp");
      total++;
      if (q0.size() > 64 && (q0[64].data !== 16'd25 || q0[64].sof !== 1'b1 || q0[64].bin !== 8'd1)) begin
         bad++;
         $display("FAIL ramp_frame1_start: got data=%0d sof=%0b bin=%0d, expected 25/1/1",
                  q0[64].data, q0[64].sof, q0[64].bin);
      end
      total++;
      if (err_cnt[0] !== 0) begin
         bad++;
         $display("FAIL ramp_start_err: got %0d pulses, expected 0", err_cnt[0]);
      end
   endtask

   task automatic test_overlap();
      clear_mon();
      capture(1, 1'b0, 1'b0);
      wait_done(1, 1'b0, -1);
      build_model(5);
      compare_q(1, "overlap");
      total++;
      if (q1.size() !== 576 || q1[512].data !== 16'd160 || q1[512].bin !== 8'd8 || q1[536].data !== 16'd184) begin
         bad++;
         $display("FAIL overlap_frame8: got size=%0d, expected 576 beats with frame 8 = 160..184", q1.size());
      end
   endtask

   task automatic test_in_valid_toggle();
      clear_mon();
      capture(0, 1'b1, 1'b0);
      wait_done(0, 1'b0, -1);
      build_model(0);
      compare_q(0, "toggle");
   endtask

   task automatic test_backpressure();
      clear_mon();
      capture(0, 1'b0, 1'b1);
      wait_done(0, 1'b1, -1);
      build_model(0);
      compare_q(0, "backpressure");
      total++;
      if (stall_bad !== 0) begin
         bad++;
         $display("FAIL stall_stable: got %0d unstable stall cycles, expected 0", stall_bad);
      end
   endtask

   task automatic test_start_err();
      clear_mon();
      capture(0, 1'b0, 1'b1);
      wait_done(0, 1'b0, 3);
      build_model(0);
      compare_q(0, "start_err");
      total++;
      if (err_cnt[0] !== 1) begin
         bad++;
         $display("FAIL start_err_pulse: got %0d pulses, expected 1", err_cnt[0]);
      end
   endtask

   task automatic test_done_collision();
      int c = 0;
      clear_mon();
      capture(0, 1'b0, 1'b1);
      while (!done0 && c < 6000) begin
         @(negedge clk);
         c++;
      end
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (3) @(negedge clk);
      build_model(0);
      compare_q(0, "collision");
      total++;
      if (busy0 !== 1'b0 || err_cnt[0] !== 1) begin
         bad++;
         $display("FAIL collision_err: got busy=%0b start_err pulses=%0d, expected 0/1", busy0, err_cnt[0]);
      end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      clear_mon();
      capture(0, 1'b0, 1'b0);
      while (!(val0 && bin0 == 8'd2) && c < 6000) begin
         @(negedge clk);
         c++;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({val0, sof0, eof0, done0, err0, busy0, dout0, bin0} !== '0) begin
            bad++;
            $display("FAIL reset_mid_%0d: got valid=%0b busy=%0b data=%0d bin=%0d, expected all 0",
                     i, val0, busy0, dout0, bin0);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      capture(0, 1'b0, 1'b0);
      wait_done(0, 1'b0, -1);
      build_model(0);
      compare_q(0, "restart");
   endtask

   initial begin
      rst        = 1'b1;
      start0     = 1'b0;
      start1     = 1'b0;
      in_valid   = 1'b0;
      data_in    = '0;
      data_ready = 1'b1;
      clear_mon();
      test_reset();
      test_ramp();
      test_overlap();
      test_in_valid_toggle();
      test_backpressure();
      test_start_err();
      test_done_collision();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
